// File: rtl/lab_access_ctrl_n.sv
// Multi-lab smart-card admission controller: one request port feeding per-lab
// occupancy counters, parity-gated entry above a threshold, and timed lockout.
module lab_access_ctrl_n #(
    parameter int NUM_LABS    = 2,
    parameter int LAB_W       = 1,
    parameter int CAP         = 30,
    parameter int RESTRICT_AT = 15,
    parameter int CNT_W       = 6,
    parameter int CODE_W      = 5,
    parameter int LOCK_LIMIT  = 3,
    parameter int LOCK_CYCLES = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [CODE_W-1:0]         smartCode,
    input  logic [LAB_W-1:0]          labSel,
    input  logic [1:0]                mode,
    input  logic [NUM_LABS-1:0]       parityPolicy,
    output logic [NUM_LABS*CNT_W-1:0] count,
    output logic [NUM_LABS-1:0]       unlock,
    output logic [NUM_LABS-1:0]       restrictionWarn,
    output logic [NUM_LABS-1:0]       fullReject,
    output logic [NUM_LABS-1:0]       exitError,
    output logic [NUM_LABS-1:0]       isFull,
    output logic [NUM_LABS-1:0]       isEmpty,
    output logic [NUM_LABS-1:0]       locked
);

    localparam int REF_W  = $clog2(LOCK_LIMIT + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } labState_e;

    function automatic logic [REF_W-1:0] refSatInc(input logic [REF_W-1:0] v);
        logic [REF_W-1:0] r;
        if (v >= REF_W'(LOCK_LIMIT)) begin
            r = REF_W'(LOCK_LIMIT);
        end else begin
            r = v + REF_W'(1);
        end
        return r;
    endfunction

    function automatic logic admitParity(input logic [CODE_W-1:0] code, input logic policy);
        return ((^code) == policy);
    endfunction

    // Stage p0: request decode shared by all labs
    logic reqVld_p0;
    logic reqEnter_p0;

    assign reqVld_p0   = ~mode[1];
    assign reqEnter_p0 = mode[0];

    for (genvar i = 0; i < NUM_LABS; i++) begin : g_lab
        labState_e          state_p1, stateNext;
        logic [CNT_W-1:0]   cnt_p1, cntNext;
        logic [REF_W-1:0]   ref_p1, refNext, refInc;
        logic [LOCK_W-1:0]  lock_p1, lockNext;
        logic               hit;
        logic               unlockNext, warnNext, fullRejNext, exitErrNext;
        logic               unlock_p1, warn_p1, fullRej_p1, exitErr_p1;
        logic               full_p1, empty_p1;

        // Out-of-range labSel never matches any lab index, so it is a no-op.
        assign hit = reqVld_p0 && (int'(labSel) == i);

        always_comb begin
            stateNext   = state_p1;
            cntNext     = cnt_p1;
            refNext     = ref_p1;
            lockNext    = lock_p1;
            refInc      = refSatInc(ref_p1);
            unlockNext  = 1'b0;
            warnNext    = 1'b0;
            fullRejNext = 1'b0;
            exitErrNext = 1'b0;

            if (state_p1 == LOCKED) begin
                if (lock_p1 <= LOCK_W'(1)) begin
                    stateNext = OPEN;
                    lockNext  = '0;
                end else begin
                    lockNext = lock_p1 - LOCK_W'(1);
                end
            end

            if (hit) begin
                if (reqEnter_p0) begin
                    if (state_p1 == LOCKED || cnt_p1 == CNT_W'(CAP)) begin
                        fullRejNext = 1'b1;
                    end else if (cnt_p1 < CNT_W'(RESTRICT_AT) ||
                                 admitParity(smartCode, parityPolicy[i])) begin
                        cntNext    = cnt_p1 + CNT_W'(1);
                        unlockNext = 1'b1;
                        refNext    = '0;
                    end else begin
                        warnNext = 1'b1;
                        if (refInc == REF_W'(LOCK_LIMIT)) begin
                            refNext   = '0;
                            stateNext = LOCKED;
                            lockNext  = LOCK_W'(LOCK_CYCLES);
                        end else begin
                            refNext = refInc;
                        end
                    end
                end else begin
                    if (cnt_p1 != '0) begin
                        cntNext    = cnt_p1 - CNT_W'(1);
                        unlockNext = 1'b1;
                    end else begin
                        exitErrNext = 1'b1;
                    end
                end
            end
        end

        // Stage p1: registered lab state and outputs
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state_p1   <= OPEN;
                cnt_p1     <= '0;
                ref_p1     <= '0;
                lock_p1    <= '0;
                unlock_p1  <= 1'b0;
                warn_p1    <= 1'b0;
                fullRej_p1 <= 1'b0;
                exitErr_p1 <= 1'b0;
                full_p1    <= 1'b0;
                empty_p1   <= 1'b1;
            end else begin
                state_p1   <= stateNext;
                cnt_p1     <= cntNext;
                ref_p1     <= refNext;
                lock_p1    <= lockNext;
                unlock_p1  <= unlockNext;
                warn_p1    <= warnNext;
                fullRej_p1 <= fullRejNext;
                exitErr_p1 <= exitErrNext;
                full_p1    <= (cntNext == CNT_W'(CAP));
                empty_p1   <= (cntNext == '0);
            end
        end

        assign count[i*CNT_W +: CNT_W] = cnt_p1;
        assign unlock[i]               = unlock_p1;
        assign restrictionWarn[i]      = warn_p1;
        assign fullReject[i]           = fullRej_p1;
        assign exitError[i]            = exitErr_p1;
        assign isFull[i]               = full_p1;
        assign isEmpty[i]              = empty_p1;
        assign locked[i]               = (state_p1 == LOCKED);
    end

endmodule

// File: tb/tb_lab_access_ctrl_n.sv
// Scoreboard bench for lab_access_ctrl_n: directed scenarios plus random traffic,
// checked against a per-lab occupancy/refusal/lockout model.
module tb_lab_access_ctrl_n;

    localparam int NL   = 3;
    localparam int LW   = 2;
    localparam int CAPV = 30;
    localparam int RA   = 15;
    localparam int CW   = 6;
    localparam int KW   = 5;
    localparam int LL   = 3;
    localparam int LC   = 8;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [KW-1:0]     smartCode;
    logic [LW-1:0]     labSel;
    logic [1:0]        mode;
    logic [NL-1:0]     parityPolicy;
    logic [NL*CW-1:0]  count;
    logic [NL-1:0]     unlock, restrictionWarn, fullReject, exitError, isFull, isEmpty, locked;

    lab_access_ctrl_n #(
        .NUM_LABS(NL), .LAB_W(LW), .CAP(CAPV), .RESTRICT_AT(RA), .CNT_W(CW),
        .CODE_W(KW), .LOCK_LIMIT(LL), .LOCK_CYCLES(LC)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .smartCode(smartCode), .labSel(labSel), .mode(mode),
        .parityPolicy(parityPolicy), .count(count), .unlock(unlock),
        .restrictionWarn(restrictionWarn), .fullReject(fullReject), .exitError(exitError),
        .isFull(isFull), .isEmpty(isEmpty), .locked(locked)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NL*CW-1:0] cnt;
        logic [NL-1:0]    unl, warn, frej, xerr, full, empty, lck;
    } exp_t;

    exp_t          sbq[$];
    int            tests = 0;
    int            fails = 0;
    int            occ[NL];
    int            refs[NL];
    int            lockLeft[NL];
    logic [NL-1:0] polSet;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int l = 0; l < NL; l++) begin
            occ[l] = 0;
            refs[l] = 0;
            lockLeft[l] = 0;
        end
    endtask

    // One clock edge of the lab rules, applied to the request that edge samples.
    task automatic modelStep(input logic [KW-1:0] code, input int lab, input logic [1:0] md,
                             output exp_t e);
        bit wl[NL];
        e.cnt = '0; e.unl = '0; e.warn = '0; e.frej = '0; e.xerr = '0;
        e.full = '0; e.empty = '0; e.lck = '0;
        for (int l = 0; l < NL; l++) begin
            wl[l] = (lockLeft[l] > 0);
            if (wl[l]) lockLeft[l]--;
        end
        if (md[1] == 1'b0 && lab < NL) begin
            if (md[0]) begin
                if (wl[lab] || occ[lab] == CAPV) begin
                    e.frej[lab] = 1'b1;
                end else if (occ[lab] < RA || ($countones(code) % 2) == int'(parityPolicy[lab])) begin
                    occ[lab]++;
                    e.unl[lab] = 1'b1;
                    refs[lab] = 0;
                end else begin
                    e.warn[lab] = 1'b1;
                    refs[lab]++;
                    if (refs[lab] >= LL) begin
                        refs[lab] = 0;
                        lockLeft[lab] = LC;
                    end
                end
            end else begin
                if (occ[lab] > 0) begin
                    occ[lab]--;
                    e.unl[lab] = 1'b1;
                end else begin
                    e.xerr[lab] = 1'b1;
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            e.cnt[l*CW +: CW] = CW'(occ[l]);
            e.full[l]  = (occ[l] == CAPV);
            e.empty[l] = (occ[l] == 0);
            e.lck[l]   = (lockLeft[l] > 0);
        end
    endtask

    task automatic step(input logic [KW-1:0] code, input int lab, input logic [1:0] md);
        exp_t e;
        @(negedge CLK);
        smartCode    = code;
        labSel       = LW'(lab);
        mode         = md;
        parityPolicy = polSet;
        modelStep(code, lab, md, e);
        sbq.push_back(e);
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    function automatic logic [CW-1:0] labCnt(input int l);
        return count[l*CW +: CW];
    endfunction

    // Monitor: every output cycle is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_count", count, e.cnt);
                chk("sb_unlock", unlock, e.unl);
                chk("sb_restrictionWarn", restrictionWarn, e.warn);
                chk("sb_fullReject", fullReject, e.frej);
                chk("sb_exitError", exitError, e.xerr);
                chk("sb_isFull", isFull, e.full);
                chk("sb_isEmpty", isEmpty, e.empty);
                chk("sb_locked", locked, e.lck);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        smartCode = '0;
        labSel = '0;
        mode = 2'b10;
        polSet = 3'b001;
        parityPolicy = polSet;
        modelReset();
        #12;
        chk("rst_count", count, '0);
        chk("rst_isEmpty", isEmpty, {NL{1'b1}});
        chk("rst_isFull", isFull, '0);
        chk("rst_locked", locked, '0);
        chk("rst_pulses", {unlock, restrictionWarn, fullReject, exitError}, '0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Fill lab 0 to the restriction threshold with arbitrary codes.
        for (int n = 0; n < RA; n++) step(KW'($urandom), 0, 2'b01);
        settle();
        chk("plan_cnt0_15", labCnt(0), 15);
        chk("plan_cnt1_0", labCnt(1), 0);
        chk("plan_empty0", isEmpty[0], 1'b0);

        // Parity gate on lab 0 (policy 1 admits odd parity).
        step(5'b00001, 0, 2'b01);
        settle();
        chk("plan_odd_admit_cnt", labCnt(0), 16);
        chk("plan_odd_admit_unlock", unlock[0], 1'b1);
        step(5'b00011, 0, 2'b01);
        settle();
        chk("plan_even_warn", restrictionWarn[0], 1'b1);
        chk("plan_even_cnt", labCnt(0), 16);

        // Lab 1 (policy 0 admits even parity): three refusals lock it.
        for (int n = 0; n < RA; n++) step(KW'($urandom), 1, 2'b01);
        for (int n = 0; n < LL; n++) step(5'b00001, 1, 2'b01);
        settle();
        chk("plan_lock1", locked[1], 1'b1);
        for (int n = 0; n < LC; n++) step(5'b00011, 1, 2'b01);
        settle();
        chk("plan_lock_last_reject", fullReject[1], 1'b1);
        chk("plan_unlock1", locked[1], 1'b0);
        step(5'b00011, 1, 2'b01);
        settle();
        chk("plan_after_lock_cnt", labCnt(1), 16);

        // Fill lab 0 to capacity, overflow attempt, then one exit.
        for (int n = 0; n < CAPV - 16; n++) step(5'b00111, 0, 2'b01);
        settle();
        chk("plan_full0", isFull[0], 1'b1);
        step(5'b00001, 0, 2'b01);
        settle();
        chk("plan_full_reject", fullReject[0], 1'b1);
        chk("plan_full_cnt", labCnt(0), 30);
        step(5'b00000, 0, 2'b00);
        settle();
        chk("plan_exit_cnt", labCnt(0), 29);
        chk("plan_exit_notfull", isFull[0], 1'b0);

        // Exit on empty lab, out-of-range lab and idle modes.
        step(5'b00000, 2, 2'b00);
        settle();
        chk("plan_exit_err", exitError[2], 1'b1);
        chk("plan_exit_err_empty", isEmpty[2], 1'b1);
        step(5'b00011, 3, 2'b01);
        step(5'b00011, 1, 2'b11);
        step(5'b00011, 0, 2'b10);

        // Lock lab 1 at 20, then assert reset between edges.
        for (int n = 0; n < 4; n++) step(5'b00011, 1, 2'b01);
        for (int n = 0; n < LL; n++) step(5'b00001, 1, 2'b01);
        step(5'b00000, 0, 2'b10);
        settle();
        chk("pre_rst_locked1", locked[1], 1'b1);
        chk("pre_rst_cnt1", labCnt(1), 20);
        #1;
        RST_N = 1'b0;
        #1;
        chk("async_rst_count", count, '0);
        chk("async_rst_isEmpty", isEmpty, {NL{1'b1}});
        chk("async_rst_locked", locked, '0);
        chk("async_rst_isFull", isFull, '0);
        chk("async_rst_pulses", {unlock, restrictionWarn, fullReject, exitError}, '0);
        mode = 2'b10;
        @(negedge CLK);
        RST_N = 1'b1;
        modelReset();

        // Random traffic, biased toward entries so labs reach the gate and the cap.
        for (int n = 0; n < 1500; n++) begin
            int r;
            int lab;
            logic [1:0] md;
            r = $urandom_range(0, 99);
            if (r < 60) md = 2'b01;
            else if (r < 90) md = 2'b00;
            else md = 2'({1'b1, 1'($urandom_range(0, 1))});
            if ($urandom_range(0, 19) == 0) lab = 3;
            else lab = $urandom_range(0, NL - 1);
            if ($urandom_range(0, 49) == 0) polSet = NL'($urandom);
            step(KW'($urandom), lab, md);
        end
        settle();
        chk("sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
